// File: rtl/arf_ctrl_pkg.sv
// Shared codes for the address register file controller: request ops, register
// function selects, one-cold register enables, output selects and FSM states.
package arf_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_FETCH = 3'b001,
    OP_PUSH  = 3'b010,
    OP_POP   = 3'b011,
    OP_JUMP  = 3'b100,
    OP_LDAR  = 3'b101
  } req_op_e;

  typedef enum logic [2:0] {
    FUN_DEC  = 3'b000,
    FUN_INC  = 3'b001,
    FUN_LOAD = 3'b010,
    FUN_CLR  = 3'b011
  } fun_sel_e;

  // Register enables are active-low: bit2 PC, bit1 AR, bit0 SP.
  localparam logic [2:0] SEL_PC   = 3'b011;
  localparam logic [2:0] SEL_AR   = 3'b101;
  localparam logic [2:0] SEL_SP   = 3'b110;
  localparam logic [2:0] SEL_NONE = 3'b111;

  localparam logic [1:0] OUT_PC = 2'b00;
  localparam logic [1:0] OUT_AR = 2'b10;
  localparam logic [1:0] OUT_SP = 2'b11;

  typedef enum logic [2:0] {
    ST_INIT_PC,
    ST_INIT_SP,
    ST_IDLE,
    ST_PRE,
    ST_MEM,
    ST_POST,
    ST_EXEC
  } state_e;

  // Reserved opcodes 11x behave as NOP.
  function automatic req_op_e decode_op(input logic [2:0] raw);
    return (raw > 3'b101) ? OP_NOP : req_op_e'(raw);
  endfunction

endpackage

// File: rtl/arf_ack_timer.sv
// Memory acknowledge watchdog: counts MEM cycles without MemAck and flags the
// cycle in which the count reaches LIMIT.
module arf_ack_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // Flags the cycle whose increment would land on LIMIT, so the abort edge
  // coincides with the counter reaching the limit.
  assign expired = enable && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/arf_controller.sv
// Sequencer for the PC/AR/SP register file: accepts one address operation at a
// time and runs the register updates and memory handshake around it.
module arf_controller
  import arf_ctrl_pkg::*;
#(
  parameter logic [15:0] STACK_TOP   = 16'hFFFF,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [15:0] req_data,
  output logic [15:0] arf_i,
  output logic [2:0]  arf_fun_sel,
  output logic [2:0]  arf_reg_sel,
  output logic [1:0]  arf_out_c_sel,
  output logic [1:0]  arf_out_d_sel,
  output logic        mem_req,
  output logic        mem_write,
  input  logic        mem_ack,
  output logic        done,
  output logic        error
);

  state_e  state;
  req_op_e op_q;
  logic    timer_clear;
  logic    timer_enable;
  logic    timer_expired;

  assign timer_clear  = (state != ST_MEM);
  assign timer_enable = (state == ST_MEM) && !mem_ack;

  arf_ack_timer #(.LIMIT(ACK_TIMEOUT)) u_ack_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // Each branch loads the outputs of the state being entered, so every output
  // is a flop. During init the state names the step issued on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_INIT_PC;
      op_q          <= OP_NOP;
      req_ready     <= 1'b0;
      arf_i         <= '0;
      arf_fun_sel   <= FUN_DEC;
      arf_reg_sel   <= SEL_NONE;
      arf_out_c_sel <= OUT_AR;
      arf_out_d_sel <= OUT_PC;
      mem_req       <= 1'b0;
      mem_write     <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every branch see pre-edge values,
      // so the defaults below are safely overridden by later assignments.
      arf_reg_sel <= SEL_NONE;
      arf_fun_sel <= FUN_DEC;
      req_ready   <= 1'b0;
      mem_req     <= 1'b0;
      mem_write   <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;

      case (state)
        ST_INIT_PC: begin
          arf_reg_sel <= SEL_PC;
          arf_fun_sel <= FUN_CLR;
          state       <= ST_INIT_SP;
        end

        ST_INIT_SP: begin
          arf_reg_sel <= SEL_SP;
          arf_fun_sel <= FUN_LOAD;
          arf_i       <= STACK_TOP;
          state       <= ST_IDLE;
        end

        ST_IDLE: begin
          if (req_ready && req_valid) begin
            op_q <= decode_op(req_op);
            case (decode_op(req_op))
              OP_FETCH: begin
                state         <= ST_MEM;
                mem_req       <= 1'b1;
                arf_out_d_sel <= OUT_PC;
              end
              OP_POP: begin
                state         <= ST_MEM;
                mem_req       <= 1'b1;
                arf_out_d_sel <= OUT_SP;
              end
              OP_PUSH: begin
                state       <= ST_PRE;
                arf_reg_sel <= SEL_SP;
                arf_fun_sel <= FUN_DEC;
              end
              OP_JUMP, OP_LDAR: begin
                state       <= ST_EXEC;
                arf_reg_sel <= (decode_op(req_op) == OP_JUMP) ? SEL_PC : SEL_AR;
                arf_fun_sel <= FUN_LOAD;
                arf_i       <= req_data;
                done        <= 1'b1;
              end
              default: begin
                state <= ST_EXEC;
                done  <= 1'b1;
              end
            endcase
          end else begin
            req_ready <= 1'b1;
          end
        end

        ST_PRE: begin
          state         <= ST_MEM;
          mem_req       <= 1'b1;
          mem_write     <= 1'b1;
          arf_out_d_sel <= OUT_SP;
        end

        ST_MEM: begin
          if (mem_ack) begin
            state <= ST_POST;
            done  <= 1'b1;
            if (op_q == OP_FETCH) begin
              arf_reg_sel <= SEL_PC;
              arf_fun_sel <= FUN_INC;
            end else if (op_q == OP_POP) begin
              arf_reg_sel <= SEL_SP;
              arf_fun_sel <= FUN_INC;
            end
          end else if (timer_expired) begin
            // Abort: only PUSH has already touched SP and must undo its DEC.
            state <= ST_POST;
            error <= 1'b1;
            if (op_q == OP_PUSH) begin
              arf_reg_sel <= SEL_SP;
              arf_fun_sel <= FUN_INC;
            end
          end else begin
            mem_req   <= 1'b1;
            mem_write <= mem_write;
          end
        end

        ST_POST, ST_EXEC: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end

        default: state <= ST_INIT_PC;
      endcase
    end
  end

endmodule

// File: tb/tb_arf_controller.sv
// Randomized bench for arf_controller: a behavioural register file plus an
// operation-level model of PC/AR/SP, memory addresses and handshake timing.
module tb_arf_controller;

  localparam int ACK_TIMEOUT = 15;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_FETCH = 3'd1;
  localparam logic [2:0] OP_PUSH  = 3'd2;
  localparam logic [2:0] OP_POP   = 3'd3;
  localparam logic [2:0] OP_JUMP  = 3'd4;
  localparam logic [2:0] OP_LDAR  = 3'd5;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_data;
  logic [15:0] arf_i;
  logic [2:0]  arf_fun_sel;
  logic [2:0]  arf_reg_sel;
  logic [1:0]  arf_out_c_sel;
  logic [1:0]  arf_out_d_sel;
  logic        mem_req;
  logic        mem_write;
  logic        mem_ack;
  logic        done;
  logic        error;

  arf_controller #(
    .STACK_TOP   (16'hFFFF),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_data      (req_data),
    .arf_i         (arf_i),
    .arf_fun_sel   (arf_fun_sel),
    .arf_reg_sel   (arf_reg_sel),
    .arf_out_c_sel (arf_out_c_sel),
    .arf_out_d_sel (arf_out_d_sel),
    .mem_req       (mem_req),
    .mem_write     (mem_write),
    .mem_ack       (mem_ack),
    .done          (done),
    .error         (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Behavioural register file driven by the controller outputs.
  logic [15:0] pc_m = 16'h5A5A;
  logic [15:0] ar_m = 16'h0000;
  logic [15:0] sp_m = 16'hA5A5;

  function automatic logic [15:0] rf_apply(input logic [2:0] f, input logic [15:0] v,
                                           input logic [15:0] d);
    case (f)
      3'b000:  return v - 16'd1;
      3'b001:  return v + 16'd1;
      3'b010:  return d;
      3'b011:  return 16'd0;
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    if (arf_reg_sel[2] === 1'b0) pc_m <= rf_apply(arf_fun_sel, pc_m, arf_i);
    if (arf_reg_sel[1] === 1'b0) ar_m <= rf_apply(arf_fun_sel, ar_m, arf_i);
    if (arf_reg_sel[0] === 1'b0) sp_m <= rf_apply(arf_fun_sel, sp_m, arf_i);
  end

  function automatic logic [15:0] obs_addr();
    case (arf_out_d_sel)
      2'b00:   return pc_m;
      2'b10:   return ar_m;
      2'b11:   return sp_m;
      default: return 16'hDEAD;
    endcase
  endfunction

  // Operation-level expectation of the architectural registers.
  logic [15:0] exp_pc = 16'h0000;
  logic [15:0] exp_ar = 16'h0000;
  logic [15:0] exp_sp = 16'hFFFF;

  // Called at a falling edge with rst_n low; releases reset and checks init.
  task automatic check_init();
    check("rst_ready",  32'(req_ready), 0);
    check("rst_regsel", 32'(arf_reg_sel), 7);
    check("rst_funsel", 32'(arf_fun_sel), 0);
    check("rst_arfi",   32'(arf_i), 0);
    check("rst_outsel", 32'({arf_out_c_sel, arf_out_d_sel}), 8);
    check("rst_mem",    32'({mem_req, mem_write}), 0);
    check("rst_pulses", 32'({done, error}), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("init1_regsel", 32'(arf_reg_sel), 3);
    check("init1_funsel", 32'(arf_fun_sel), 3);
    check("init1_ready",  32'(req_ready), 0);
    @(negedge clk);
    check("init2_regsel", 32'(arf_reg_sel), 6);
    check("init2_funsel", 32'(arf_fun_sel), 2);
    check("init2_arfi",   32'(arf_i), 32'hFFFF);
    check("init2_ready",  32'(req_ready), 0);
    @(negedge clk);
    check("init3_ready",  32'(req_ready), 1);
    check("init3_regsel", 32'(arf_reg_sel), 7);
    exp_pc = 16'h0000;
    exp_sp = 16'hFFFF;
    check("init_pc", 32'(pc_m), 32'(exp_pc));
    check("init_sp", 32'(sp_m), 32'(exp_sp));
    check("init_ar", 32'(ar_m), 32'(exp_ar));
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle_ready"}, 32'(req_ready), 1);
  endtask

  // ack_delay < 0: never acknowledge; otherwise ack in MEM cycle ack_delay+1.
  task automatic do_op(input logic [2:0] op, input logic [15:0] data, input int ack_delay,
                       input string tag);
    int          cyc, mem_cycles, dones, errs, done_cyc, err_cyc, last_mem, ready_cyc, exp_mem;
    logic [15:0] addr, exp_addr, done_arfi;
    logic [2:0]  done_fun;
    logic [1:0]  dsel0;
    logic        wr, moved;
    bit          is_mem, success;

    mem_cycles = 0; dones = 0; errs = 0; done_cyc = 0; err_cyc = 0; last_mem = 0;
    ready_cyc = 0; addr = 16'h0; done_arfi = 16'h0; done_fun = 3'h0; dsel0 = 2'h0;
    wr = 1'b0; moved = 1'b0;

    wait_ready(tag);
    is_mem   = (op == OP_FETCH) || (op == OP_PUSH) || (op == OP_POP);
    success  = !is_mem || (ack_delay >= 0 && ack_delay < ACK_TIMEOUT);
    exp_mem  = !is_mem ? 0 : (success ? ack_delay + 1 : ACK_TIMEOUT);
    exp_addr = (op == OP_FETCH) ? exp_pc : (op == OP_PUSH) ? exp_sp - 16'd1 : exp_sp;

    req_valid = 1'b1;
    req_op    = op;
    req_data  = data;
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 3'($urandom);
    req_data  = 16'($urandom);
    check({tag, "_ready_drop"}, 32'(req_ready), 0);

    cyc = 1;
    while (cyc <= 60 && ready_cyc == 0) begin
      if (req_ready === 1'b1) begin
        ready_cyc = cyc;
      end else begin
        if (done === 1'b1) begin
          dones++;
          done_cyc  = cyc;
          done_fun  = arf_fun_sel;
          done_arfi = arf_i;
        end
        if (error === 1'b1) begin
          errs++;
          err_cyc = cyc;
        end
        if (mem_req === 1'b1) begin
          mem_cycles++;
          if (mem_cycles == 1) begin
            addr  = obs_addr();
            wr    = mem_write;
            dsel0 = arf_out_d_sel;
          end else if (arf_out_d_sel !== dsel0 || mem_write !== wr) begin
            moved = 1'b1;
          end
          last_mem = cyc;
          mem_ack  = (ack_delay >= 0 && mem_cycles == ack_delay + 1);
        end else begin
          mem_ack = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    mem_ack = 1'b0;

    check({tag, "_ready_back"}, (ready_cyc != 0) ? 1 : 0, 1);
    check({tag, "_mem_cycles"}, mem_cycles, exp_mem);
    check({tag, "_done_count"}, dones, success ? 1 : 0);
    check({tag, "_error_count"}, errs, success ? 0 : 1);
    if (success) begin
      check({tag, "_done_cycle"}, done_cyc, is_mem ? last_mem + 1 : 1);
      check({tag, "_ready_cycle"}, ready_cyc, done_cyc + 1);
    end else begin
      check({tag, "_error_cycle"}, err_cyc, last_mem + 1);
      check({tag, "_ready_cycle"}, ready_cyc, err_cyc + 1);
    end
    if (is_mem) begin
      check({tag, "_mem_addr"}, 32'(addr), 32'(exp_addr));
      check({tag, "_mem_write"}, 32'(wr), (op == OP_PUSH) ? 1 : 0);
      check({tag, "_mem_stable"}, 32'(moved), 0);
    end
    if (op == OP_JUMP || op == OP_LDAR) begin
      check({tag, "_load_fun"}, 32'(done_fun), 2);
      check({tag, "_load_data"}, 32'(done_arfi), 32'(data));
    end

    if (success) begin
      case (op)
        OP_FETCH: exp_pc = exp_pc + 16'd1;
        OP_PUSH:  exp_sp = exp_sp - 16'd1;
        OP_POP:   exp_sp = exp_sp + 16'd1;
        OP_JUMP:  exp_pc = data;
        OP_LDAR:  exp_ar = data;
        default:  ;
      endcase
    end
    check({tag, "_pc"}, 32'(pc_m), 32'(exp_pc));
    check({tag, "_ar"}, 32'(ar_m), 32'(exp_ar));
    check({tag, "_sp"}, 32'(sp_m), 32'(exp_sp));
  endtask

  // A MemAck pulse while idle must have no effect.
  task automatic stray_ack();
    wait_ready("stray");
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("stray_done",  32'(done), 0);
    check("stray_ready", 32'(req_ready), 1);
    check("stray_mem",   32'(mem_req), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_data  = 16'd0;
    mem_ack   = 1'b0;
    #1 rst_n  = 1'b0;
    @(negedge clk);
    check_init();

    do_op(OP_JUMP,  16'h1234, 0, "jump");
    do_op(OP_FETCH, 16'h0000, 3, "fetch");
    do_op(OP_PUSH,  16'($urandom), 1, "push");
    do_op(OP_POP,   16'($urandom), 1, "pop");
    check("push_pop_sp_net", 32'(sp_m), 32'hFFFF);
    do_op(OP_PUSH,  16'h0000, -1, "push_timeout");
    do_op(OP_FETCH, 16'h0000, -1, "fetch_timeout");
    do_op(OP_POP,   16'h0000, ACK_TIMEOUT - 1, "pop_ack_at_limit");
    do_op(OP_LDAR,  16'hBEEF, 0, "ldar");
    do_op(OP_JUMP,  16'hFFFF, 0, "jump_top");
    do_op(OP_FETCH, 16'h0000, 0, "fetch_wrap");
    check("pc_wrapped", 32'(pc_m), 0);
    do_op(OP_NOP,   16'h0000, 0, "nop");
    do_op(3'b110,   16'h0000, 0, "op_110");
    do_op(3'b111,   16'h0000, 0, "op_111");
    stray_ack();

    // Reset in the middle of a FETCH memory access.
    wait_ready("midrst");
    req_valid = 1'b1;
    req_op    = OP_FETCH;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("midrst_memreq_before", 32'(mem_req), 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_memreq_async", 32'(mem_req), 0);
    check("midrst_error_async",  32'(error), 0);
    check("midrst_regsel_async", 32'(arf_reg_sel), 7);
    @(negedge clk);
    check("midrst_error_held", 32'(error), 0);
    check_init();

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      int         r;
      op = 3'($urandom_range(0, 7));
      r  = $urandom_range(0, 19);
      if ($urandom_range(0, 5) == 0) stray_ack();
      do_op(op, 16'($urandom), (r >= 17) ? -1 : r, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/arf_controller.md
Name: arf_controller

Overview:
- Sequencer that drives the control inputs of the address register file (PC, AR, SP): FunSel, RegSel, OutCSel, OutDSel and the load data I.
- Accepts one address operation at a time (fetch, push, pop, jump, load AR) over a valid/ready handshake.
- Runs the matching memory handshake and updates the registers before and after each memory access.
- Sits between the instruction control unit and the register file/memory pair; the memory address is the register file's OutD, selected by this block.

Parameters:
- STACK_TOP, 16'hFFFF, value loaded into SP during post-reset init.
- ACK_TIMEOUT, 15, MemAck wait limit in cycles (1..255) before abort.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- ReqValid  in  1  operation request valid
- ReqReady  out  1  block can accept a request
- ReqOp  in  3  000 NOP, 001 FETCH, 010 PUSH, 011 POP, 100 JUMP, 101 LDAR; 11x treated as NOP
- ReqData  in  16  operand for JUMP/LDAR
- ArfI  out  16  register file load data
- ArfFunSel  out  3  register function select
- ArfRegSel  out  3  active-low enables: bit2 PC, bit1 AR, bit0 SP
- ArfOutCSel  out  2  held at 2'b10 (AR)
- ArfOutDSel  out  2  memory address source: 00 PC, 11 SP
- MemReq  out  1  memory access request
- MemWrite  out  1  1 write, 0 read; valid while MemReq is high
- MemAck  in  1  memory completion, one-cycle pulse
- Done  out  1  one-cycle pulse when an operation completes
- Error  out  1  one-cycle pulse when an operation aborts on timeout

Behaviour:
- All outputs are registered.
- Reset values: ReqReady 0, ArfRegSel 3'b111, ArfFunSel 3'b000, ArfI 0, ArfOutDSel 00, ArfOutCSel 10, MemReq 0, MemWrite 0, Done 0, Error 0.
- FunSel codes: DEC 000, INC 001, LOAD 010, CLR 011.
- Idle rule: any cycle not listed below drives ArfRegSel=111, so no register changes.
- States: INIT_PC, INIT_SP, IDLE, PRE, MEM, POST, EXEC.
- Init sequence:
  - INIT_PC: RegSel=011, FunSel=CLR.
  - INIT_SP: RegSel=110, FunSel=LOAD, ArfI=STACK_TOP.
  - Then IDLE. ReqReady first goes high 2 cycles after Reset deasserts.
- IDLE: ReqReady=1. A request is accepted on the edge where ReqValid&ReqReady is high; ReqReady drops on the next cycle. ReqOp and ReqData are captured at acceptance.
- JUMP / LDAR: EXEC for 1 cycle (RegSel 011 / 101, FunSel=LOAD, ArfI=captured data), with Done=1 in that same cycle, then IDLE.
- NOP: EXEC with RegSel=111 and Done=1.
- FETCH:
  - MEM: OutDSel=00, MemReq=1, MemWrite=0.
  - On MemAck, go to POST: RegSel=011, FunSel=INC, Done=1.
- PUSH:
  - PRE: RegSel=110, FunSel=DEC.
  - MEM: OutDSel=11, MemWrite=1.
  - On MemAck: Done=1 on the next cycle, then IDLE.
- POP:
  - MEM: OutDSel=11, MemWrite=0.
  - On MemAck, go to POST: RegSel=110, FunSel=INC, Done=1.
- MemReq stays high through MEM until the cycle after MemAck is sampled. OutDSel stays stable throughout MEM.
- Timeout: an 8-bit counter clears on entering MEM and increments each MEM cycle without MemAck. When it reaches ACK_TIMEOUT, the operation aborts:
  - MemReq drops and Error pulses.
  - FETCH and POP make no register update.
  - PUSH issues one SP INC to restore SP, concurrent with Error.
  - Done is not asserted. The block returns to IDLE.
- MemAck arriving in the same cycle the counter reaches the limit counts as success.
- MemAck outside MEM is ignored.
- Register arithmetic wraps inside the register file: PC FFFF→0000, SP 0000→FFFF. No detection.
- Reset asserted mid-operation: all outputs go to reset values immediately and the init sequence reruns. Any in-flight memory request is dropped without an Error pulse.

Decomposition:
- Package arf_ctrl_pkg: ReqOp codes, FunSel codes, RegSel one-cold masks (PC/AR/SP/NONE), OutSel codes, state enum.
- One sub-module: arf_ack_timer (counter, clear, enable, limit compare, expired flag).

Test Plan:
- Reset release → RegSel 011/CLR, then 110/LOAD with ArfI=FFFF, then ReqReady=1 on cycle 3.
- JUMP with ReqData=1234 → one EXEC cycle: RegSel=011, FunSel=010, ArfI=1234, Done=1; ReqReady back the next cycle.
- FETCH, MemAck after 3 cycles → MemReq for 4 cycles with OutDSel=00, MemWrite=0, then RegSel=011 INC with Done.
- PUSH then POP, each acked after 1 cycle:
  - PUSH: SP DEC before MemReq (write, OutDSel=11).
  - POP: read, then SP INC.
  - Net SP back to FFFF.
- PUSH with MemAck never asserted, ACK_TIMEOUT=15 → Error on the 15th MEM cycle, SP INC issued, no Done.
- Reset pulled low during FETCH MEM → MemReq=0 asynchronously, no Error, init sequence repeats.
